// File: rtl/pulse_seq_ctrl.sv
// Trapezoidal pulse sequencer: delay, then repeated rise/high/fall/low phases with
// tick-counted durations and a saturating linear ramp on the amplitude word.
module pulse_seq_ctrl #(
  parameter int TW = 16,
  parameter int AW = 12,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [TW-1:0]        cfg_td,
  input  logic [TW-1:0]        cfg_tr,
  input  logic [TW-1:0]        cfg_tw,
  input  logic [TW-1:0]        cfg_tf,
  input  logic [TW-1:0]        cfg_tp,
  input  logic [CW-1:0]        cfg_ncyc,
  input  logic signed [AW-1:0] cfg_iv,
  input  logic signed [AW-1:0] cfg_pv,
  input  logic signed [AW-1:0] cfg_rstep,
  input  logic signed [AW-1:0] cfg_fstep,
  output logic signed [AW-1:0] level,
  output logic [2:0]           phase,
  output logic                 busy,
  output logic                 cycle_done,
  output logic [CW-1:0]        cyc_cnt,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_DELAY = 3'd1,
    PH_RISE  = 3'd2,
    PH_HIGH  = 3'd3,
    PH_FALL  = 3'd4,
    PH_LOW   = 3'd5
  } phase_t;

  phase_t                phase_q, phase_d, enter_ph, last_ph;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  level_q, level_d;
  logic [CW-1:0]         cyc_cnt_q, cyc_cnt_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  load_cfg, enter;

  logic [TW-1:0]         td_q, tr_q, tw_q, tf_q, tp_q;
  logic [CW-1:0]         ncyc_q;
  logic signed [AW-1:0]  iv_q, pv_q, rstep_q, fstep_q;

  // While idle the live cfg_* inputs drive the start decision; once running,
  // the copies captured at start are used so host writes cannot disturb a run.
  logic                  idle;
  logic [TW-1:0]         e_td, e_tr, e_tw, e_tf, e_tp, tl;
  logic [CW-1:0]         e_ncyc;
  logic signed [AW-1:0]  e_iv, e_pv, e_rstep, e_fstep;
  logic [TW+1:0]         sum_rwf;
  logic [5:1]            nz;
  logic                  bad, run_end, rise_up, fall_up;

  assign idle    = (phase_q == PH_IDLE);
  assign e_td    = idle ? cfg_td    : td_q;
  assign e_tr    = idle ? cfg_tr    : tr_q;
  assign e_tw    = idle ? cfg_tw    : tw_q;
  assign e_tf    = idle ? cfg_tf    : tf_q;
  assign e_tp    = idle ? cfg_tp    : tp_q;
  assign e_ncyc  = idle ? cfg_ncyc  : ncyc_q;
  assign e_iv    = idle ? cfg_iv    : iv_q;
  assign e_pv    = idle ? cfg_pv    : pv_q;
  assign e_rstep = idle ? cfg_rstep : rstep_q;
  assign e_fstep = idle ? cfg_fstep : fstep_q;

  assign sum_rwf = {2'b00, e_tr} + {2'b00, e_tw} + {2'b00, e_tf};
  assign bad     = (sum_rwf == '0) || ((e_tp != '0) && ({2'b00, e_tp} < sum_rwf));
  assign tl      = (e_tp != '0) ? (e_tp - sum_rwf[TW-1:0]) : '0;
  assign nz      = {tl != '0, e_tf != '0, e_tw != '0, e_tr != '0, e_td != '0};
  assign last_ph = nz[5] ? PH_LOW : nz[4] ? PH_FALL : nz[3] ? PH_HIGH : PH_RISE;
  assign run_end = (e_tp == '0) || ((e_ncyc != '0) && (cyc_cnt_q + CW'(1) == e_ncyc));
  assign rise_up = (e_pv >= e_iv);
  assign fall_up = (e_iv >= e_pv);

  // First phase at or after 'from' whose duration is nonzero.
  function automatic phase_t pick(input logic [5:1] nzv, input logic [2:0] from);
    phase_t res;
    logic   found;
    res   = PH_IDLE;
    found = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (!found && nzv[i] && (3'(i) >= from)) begin
        res   = phase_t'(3'(i));
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // One ramp step, clamped at target so the level never overshoots it.
  function automatic logic signed [AW-1:0] ramp(input logic signed [AW-1:0] base,
                                                input logic signed [AW-1:0] step,
                                                input logic signed [AW-1:0] target,
                                                input logic up);
    logic signed [AW:0] sum;
    sum = {base[AW-1], base} + {step[AW-1], step};
    if (up ? (sum > {target[AW-1], target}) : (sum < {target[AW-1], target}))
      return target;
    return sum[AW-1:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    cyc_cnt_d = cyc_cnt_q;
    cfg_err_d = cfg_err_q;
    load_cfg  = 1'b0;
    enter     = 1'b0;
    enter_ph  = PH_IDLE;

    if (idle) begin
      if (start && !stop) begin
        if (bad) begin
          cfg_err_d = 1'b1;
        end else begin
          cfg_err_d = 1'b0;
          cyc_cnt_d = '0;
          load_cfg  = 1'b1;
          enter     = 1'b1;
          enter_ph  = pick(nz, 3'(PH_DELAY));
        end
      end
    end else if (stop) begin
      phase_d = PH_IDLE;
      level_d = e_iv;
    end else if (cnt_q == TW'(1)) begin
      if (phase_q == last_ph) begin
        cyc_cnt_d = cyc_cnt_q + CW'(1);
        if (run_end) begin
          phase_d = PH_IDLE;
          level_d = e_iv;
        end else begin
          enter    = 1'b1;
          enter_ph = pick(nz, 3'(PH_RISE));
        end
      end else begin
        enter    = 1'b1;
        enter_ph = pick(nz, 3'(phase_q) + 3'd1);
      end
    end else begin
      cnt_d = cnt_q - TW'(1);
      if (phase_q == PH_RISE) level_d = ramp(level_q, e_rstep, e_pv, rise_up);
      if (phase_q == PH_FALL) level_d = ramp(level_q, e_fstep, e_iv, fall_up);
    end

    if (enter) begin
      phase_d = enter_ph;
      case (enter_ph)
        PH_DELAY: begin cnt_d = e_td; level_d = e_iv; end
        PH_RISE:  begin cnt_d = e_tr; level_d = ramp(e_iv, e_rstep, e_pv, rise_up); end
        PH_HIGH:  begin cnt_d = e_tw; level_d = e_pv; end
        PH_FALL:  begin cnt_d = e_tf; level_d = ramp(e_pv, e_fstep, e_iv, fall_up); end
        PH_LOW:   begin cnt_d = tl;   level_d = e_iv; end
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      level_q   <= '0;
      cyc_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      cyc_cnt_q <= cyc_cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // NOTE: config copies carry no reset; they are only read while busy, after a start has loaded them.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      td_q    <= cfg_td;
      tr_q    <= cfg_tr;
      tw_q    <= cfg_tw;
      tf_q    <= cfg_tf;
      tp_q    <= cfg_tp;
      ncyc_q  <= cfg_ncyc;
      iv_q    <= cfg_iv;
      pv_q    <= cfg_pv;
      rstep_q <= cfg_rstep;
      fstep_q <= cfg_fstep;
    end
  end

  assign level      = level_q;
  assign phase      = 3'(phase_q);
  assign busy       = !idle;
  assign cycle_done = !idle && (cnt_q == TW'(1)) && (phase_q == last_ph);
  assign cyc_cnt    = cyc_cnt_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl: cycle-by-cycle traces against hand-computed phases and levels.
module tb_pulse_seq_ctrl;

  localparam int TW = 16;
  localparam int AW = 12;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst, start, stop;
  logic [TW-1:0]        cfg_td, cfg_tr, cfg_tw, cfg_tf, cfg_tp;
  logic [CW-1:0]        cfg_ncyc;
  logic signed [AW-1:0] cfg_iv, cfg_pv, cfg_rstep, cfg_fstep;
  logic signed [AW-1:0] level;
  logic [2:0]           phase;
  logic                 busy, cycle_done, cfg_err;
  logic [CW-1:0]        cyc_cnt;

  int checks = 0;
  int failures = 0;

  pulse_seq_ctrl #(.TW(TW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_td(cfg_td), .cfg_tr(cfg_tr), .cfg_tw(cfg_tw), .cfg_tf(cfg_tf), .cfg_tp(cfg_tp),
    .cfg_ncyc(cfg_ncyc), .cfg_iv(cfg_iv), .cfg_pv(cfg_pv),
    .cfg_rstep(cfg_rstep), .cfg_fstep(cfg_fstep),
    .level(level), .phase(phase), .busy(busy), .cycle_done(cycle_done),
    .cyc_cnt(cyc_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int td, tr, tw, tf, tp, ncyc, iv, pv, rs, fs);
    cfg_td = TW'(td); cfg_tr = TW'(tr); cfg_tw = TW'(tw); cfg_tf = TW'(tf); cfg_tp = TW'(tp);
    cfg_ncyc = CW'(ncyc); cfg_iv = AW'(iv); cfg_pv = AW'(pv);
    cfg_rstep = AW'(rs); cfg_fstep = AW'(fs);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    checks++;
    if ({phase, level, busy, cycle_done, cyc_cnt, cfg_err} !== {3'd0, 12'sd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got ph=%0d lvl=%0d busy=%b done=%b cnt=%0d err=%b, want all zero",
               phase, level, busy, cycle_done, cyc_cnt, cfg_err);
    end
  endtask

  task automatic test_periodic();
    int exp_ph[23]  = '{1,1,2,2,3,3,3,4,5,5,5,5, 2,2,3,3,3,4,5,5,5,5, 0};
    int exp_lvl[23] = '{0,0,50,100,100,100,100,0,0,0,0,0, 50,100,100,100,100,0,0,0,0,0, 0};
    do_reset();
    set_cfg(2, 2, 3, 1, 10, 2, 0, 100, 50, -100);
    do_start();
    for (int c = 1; c <= 23; c++) begin
      logic       e_done;
      logic [7:0] e_cnt;
      e_done = (c == 12) || (c == 22);
      e_cnt  = (c <= 12) ? 8'd0 : (c <= 22) ? 8'd1 : 8'd2;
      checks++;
      if ({phase, level, cycle_done, cyc_cnt, busy} !==
          {3'(exp_ph[c-1]), 12'(exp_lvl[c-1]), e_done, e_cnt, exp_ph[c-1] != 0}) begin
        failures++;
        $display("FAIL periodic cyc=%0d: got ph=%0d lvl=%0d done=%b cnt=%0d busy=%b, want ph=%0d lvl=%0d done=%b cnt=%0d",
                 c, phase, level, cycle_done, cyc_cnt, busy, exp_ph[c-1], exp_lvl[c-1], e_done, e_cnt);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    int exp_ph[6]   = '{2,2,2,3,4,0};
    int exp_pos[6]  = '{60,100,100,100,0,0};
    int exp_neg[6]  = '{-30,-40,-40,-40,0,0};
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      if (pass == 0) set_cfg(0, 3, 1, 1, 0, 0, 0, 100, 60, -100);
      else           set_cfg(0, 3, 1, 1, 0, 0, 0, -40, -30, 40);
      do_start();
      for (int c = 1; c <= 6; c++) begin
        int e_lvl;
        e_lvl = (pass == 0) ? exp_pos[c-1] : exp_neg[c-1];
        checks++;
        if ({phase, level} !== {3'(exp_ph[c-1]), 12'(e_lvl)}) begin
          failures++;
          $display("FAIL saturation pass=%0d cyc=%0d: got ph=%0d lvl=%0d, want ph=%0d lvl=%0d",
                   pass, c, phase, level, exp_ph[c-1], e_lvl);
        end
        step();
      end
    end
  endtask

  task automatic test_zero_phases();
    int exp_ph[9]  = '{2,2,3,3,2,2,3,3,0};
    int exp_lvl[9] = '{50,100,100,100,50,100,100,100,0};
    do_reset();
    set_cfg(0, 2, 2, 0, 4, 2, 0, 100, 50, 0);
    do_start();
    for (int c = 1; c <= 9; c++) begin
      logic e_done;
      e_done = (c == 4) || (c == 8);
      checks++;
      if ({phase, level, cycle_done} !== {3'(exp_ph[c-1]), 12'(exp_lvl[c-1]), e_done}) begin
        failures++;
        $display("FAIL zero_phases cyc=%0d: got ph=%0d lvl=%0d done=%b, want ph=%0d lvl=%0d done=%b",
                 c, phase, level, cycle_done, exp_ph[c-1], exp_lvl[c-1], e_done);
      end
      step();
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    set_cfg(0, 2, 2, 2, 5, 0, 7, 20, 5, -5);
    do_start();
    checks++;
    if ({cfg_err, phase, busy, level} !== {1'b1, 3'd0, 1'b0, 12'sd0}) begin
      failures++;
      $display("FAIL cfg_err_short_tp: got err=%b ph=%0d busy=%b lvl=%0d, want err=1 ph=0 busy=0 lvl=0",
               cfg_err, phase, busy, level);
    end
    cfg_tp = TW'(6);
    do_start();
    checks++;
    if ({cfg_err, phase, level} !== {1'b0, 3'd2, 12'sd12}) begin
      failures++;
      $display("FAIL cfg_err_clear: got err=%b ph=%0d lvl=%0d, want err=0 ph=2 lvl=12",
               cfg_err, phase, level);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 33, 20, 5, -5);
    do_start();
    checks++;
    if ({cfg_err, phase, level} !== {1'b1, 3'd0, 12'sd7}) begin
      failures++;
      $display("FAIL cfg_err_zero_len: got err=%b ph=%0d lvl=%0d, want err=1 ph=0 lvl=7",
               cfg_err, phase, level);
    end
  endtask

  task automatic test_stop_reset();
    do_reset();
    set_cfg(0, 1, 3, 1, 8, 0, 5, 50, 45, -45);
    do_start();
    for (int c = 1; c < 10; c++) step();
    checks++;
    if ({phase, cyc_cnt} !== {3'd3, 8'd1}) begin
      failures++;
      $display("FAIL stop_pre: got ph=%0d cnt=%0d, want ph=3 cnt=1", phase, cyc_cnt);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({phase, level, busy, cycle_done, cyc_cnt} !== {3'd0, 12'sd5, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL stop_high: got ph=%0d lvl=%0d busy=%b done=%b cnt=%0d, want ph=0 lvl=5 busy=0 done=0 cnt=1",
               phase, level, busy, cycle_done, cyc_cnt);
    end
    cfg_tp = TW'(2);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({phase, busy, cfg_err, cyc_cnt} !== {3'd0, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL start_stop_same: got ph=%0d busy=%b err=%b cnt=%0d, want ph=0 busy=0 err=0 cnt=1",
               phase, busy, cfg_err, cyc_cnt);
    end
    set_cfg(0, 3, 1, 1, 0, 0, 5, 50, 10, -10);
    do_start();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({phase, level, busy, cycle_done, cyc_cnt, cfg_err} !== {3'd0, 12'sd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_in_rise: got ph=%0d lvl=%0d busy=%b done=%b cnt=%0d err=%b, want all zero",
               phase, level, busy, cycle_done, cyc_cnt, cfg_err);
    end
  endtask

  task automatic test_single_shot();
    int exp_ph[7]  = '{1,2,3,3,4,0,0};
    int exp_lvl[7] = '{0,80,80,80,0,0,0};
    do_reset();
    set_cfg(1, 1, 2, 1, 0, 0, 0, 80, 80, -80);
    do_start();
    for (int c = 1; c <= 7; c++) begin
      logic       e_done;
      logic [7:0] e_cnt;
      e_done = (c == 5);
      e_cnt  = (c >= 6) ? 8'd1 : 8'd0;
      checks++;
      if ({phase, level, cycle_done, cyc_cnt, cfg_err} !==
          {3'(exp_ph[c-1]), 12'(exp_lvl[c-1]), e_done, e_cnt, 1'b0}) begin
        failures++;
        $display("FAIL single_shot cyc=%0d: got ph=%0d lvl=%0d done=%b cnt=%0d err=%b, want ph=%0d lvl=%0d done=%b cnt=%0d err=0",
                 c, phase, level, cycle_done, cyc_cnt, cfg_err, exp_ph[c-1], exp_lvl[c-1], e_done, e_cnt);
      end
      if (c == 2) begin
        set_cfg(4, 2, 2, 2, 20, 3, 9, 60, 30, -30);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    test_reset();
    test_periodic();
    test_saturation();
    test_zero_phases();
    test_cfg_err();
    test_stop_reset();
    test_single_shot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
